// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// access-size encodings, the default bus timeout and the legality/strobe rules.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_TIMEOUT = 255;

    // Unsigned variants exist only for loads; halfwords and words must be naturally aligned.
    function automatic logic access_legal(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3,
                                                input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (f3)
            F3_B:    strb = 4'b0001 << addr_lo;
            F3_H:    strb = 4'b0011 << addr_lo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: picks the addressed byte/halfword lane
// out of a bus word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_addr_lo,
    input  logic [2:0]            i_funct3,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [7:0]  w_lanes [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lanes[gi] = i_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_lanes[i_addr_lo];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_B:    o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_H:    o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: turns a pipeline load/store into a single
// request/grant/rvalid bus transaction, stalling the pipeline until it completes.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = LSU_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_m,
    input  logic                  memread_m,
    input  logic                  memwrite_m,
    input  logic [2:0]            funct3_m,
    input  logic [DATA_WIDTH-1:0] addr_m,
    input  logic [DATA_WIDTH-1:0] wdata_m,
    output logic                  stall_m,
    output logic [DATA_WIDTH-1:0] readdata_m,
    output logic                  access_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_wstrb,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t            r_state;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [DATA_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic [3:0]            r_bus_wstrb;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_access_err;
    logic [1:0]            r_lane;
    logic [2:0]            r_funct3;

    logic                  w_access;
    logic                  w_is_load;
    logic                  w_legal;
    logic [DATA_WIDTH-1:0] w_wdata_rep;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_access  = valid_m & (memread_m | memwrite_m);
    assign w_is_load = memread_m;
    assign w_legal   = w_access & access_legal(w_is_load, funct3_m, addr_m[1:0]);

    // Each byte lane carries the store byte/halfword that would land there,
    // so the slave only needs the strobes to pick the right lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wlane
            always_comb begin
                w_wdata_rep[8*gi +: 8] = wdata_m[8*gi +: 8];
                if (funct3_m == F3_B)
                    w_wdata_rep[8*gi +: 8] = wdata_m[7:0];
                else if (funct3_m == F3_H)
                    w_wdata_rep[8*gi +: 8] = wdata_m[8*(gi%2) +: 8];
            end
        end
    endgenerate

    lsu_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .i_rdata   (bus_rdata),
        .i_addr_lo (r_lane),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    // The IDLE term lets the pipeline freeze in the same cycle the access is seen.
    assign stall_m = ~rst & ((r_state == ST_REQ) | (r_state == ST_WAIT) |
                             ((r_state == ST_IDLE) & w_legal));

    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_wstrb  = r_bus_wstrb;
    assign readdata_m = r_readdata;
    assign access_err = r_access_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_wstrb  <= 4'b0000;
            r_readdata   <= '0;
            r_access_err <= 1'b0;
            r_lane       <= 2'b00;
            r_funct3     <= 3'b000;
        end else begin
            r_access_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access && !w_legal) begin
                        r_access_err <= 1'b1;
                    end else if (w_legal) begin
                        r_state     <= ST_REQ;
                        r_wait_cnt  <= '0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= ~w_is_load;
                        r_bus_addr  <= {addr_m[DATA_WIDTH-1:2], 2'b00};
                        r_bus_wdata <= w_wdata_rep;
                        r_bus_wstrb <= w_is_load ? 4'b0000 : store_strobe(funct3_m, addr_m[1:0]);
                        r_lane      <= addr_m[1:0];
                        r_funct3    <= funct3_m;
                    end
                end

                // Completion wins over timeout when both land in the same cycle.
                ST_REQ: begin
                    if (bus_gnt && r_bus_we) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (bus_gnt && bus_rvalid) begin
                        r_bus_req  <= 1'b0;
                        r_readdata <= w_load_data;
                        r_state    <= ST_DONE;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        r_bus_req    <= 1'b0;
                        r_readdata   <= '0;
                        r_access_err <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (bus_gnt) begin
                            r_bus_req <= 1'b0;
                            r_state   <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (bus_rvalid) begin
                        r_readdata <= w_load_data;
                        r_state    <= ST_DONE;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        r_readdata   <= '0;
                        r_access_err <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized accesses
// checked against an arithmetic reference of alignment, strobes and extension.
module tb_mem_lsu;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m, memread_m, memwrite_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m, wdata_m;
    logic        stall_m;
    logic [31:0] readdata_m;
    logic        access_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_txn   = 0;
    logic [31:0] exp_rd  = 32'h0;

    always #5 clk = ~clk;

    mem_lsu #(
        .DATA_WIDTH(32),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_m    (valid_m),
        .memread_m  (memread_m),
        .memwrite_m (memwrite_m),
        .funct3_m   (funct3_m),
        .addr_m     (addr_m),
        .wdata_m    (wdata_m),
        .stall_m    (stall_m),
        .readdata_m (readdata_m),
        .access_err (access_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference rules written from the access-size table, not from the RTL.
    function automatic bit ref_legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (ld) begin
            if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        end else begin
            if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        end
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        int size, off;
        size = 1 << f3[1:0];
        off  = a % 4;
        for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + size);
        return s;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // gd: extra REQ cycles before grant; rvd: cycles from grant to rvalid (0 = same cycle).
    task automatic run_access(input bit vld, input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int gd, input int rvd, input logic [31:0] rword,
                              input bit no_rv);
        bit is_access, legal, done;
        int k, stalls, exp_stalls;
        is_access = vld && (rd || wr);
        legal     = is_access && ref_legal(rd, f3, addr);

        @(posedge clk); #1;
        valid_m = vld; memread_m = rd; memwrite_m = wr;
        funct3_m = f3; addr_m = addr; wdata_m = wd;
        @(negedge clk);
        check("idle_stall", {31'b0, stall_m}, {31'b0, legal});
        check("idle_req", {31'b0, bus_req}, 32'd0);

        if (!legal) begin
            @(posedge clk); #1;
            valid_m = 1'b0;
            @(negedge clk);
            check("err_pulse", {31'b0, access_err}, {31'b0, is_access});
            check("illegal_no_req", {31'b0, bus_req}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("err_clear", {31'b0, access_err}, 32'd0);
            n_txn++;
            $display("[TB] txn %0d access=%0d ld=%0d f3=%0d addr=%h rejected", n_txn, is_access, rd, f3, addr);
            return;
        end

        k = 0; stalls = 0; done = 0;
        while (!done && k < TO + 8) begin
            @(posedge clk); #1;
            k++;
            bus_gnt    = (k == gd + 1);
            bus_rvalid = rd && !no_rv && (k == gd + 1 + rvd);
            bus_rdata  = bus_rvalid ? rword : $urandom;
            if (k <= gd + 1) begin
                check("req_high", {31'b0, bus_req}, 32'd1);
                check("req_addr", bus_addr, addr & 32'hFFFF_FFFC);
                check("req_we", {31'b0, bus_we}, {31'b0, !rd});
                if (!rd) begin
                    check("req_wstrb", {28'b0, bus_wstrb}, {28'b0, ref_strb(f3, addr)});
                    check("req_wdata", bus_wdata, ref_wdata(f3, wd));
                end
            end
            @(negedge clk);
            if (stall_m) begin
                stalls++;
                if (k > gd + 1) check("req_dropped", {31'b0, bus_req}, 32'd0);
            end else begin
                done = 1;
            end
        end
        if (!done) check("done_bound", 32'd0, 32'd1);

        if (!rd)        exp_stalls = gd + 1;
        else if (no_rv) exp_stalls = TO;
        else            exp_stalls = gd + 1 + rvd;
        if (rd) exp_rd = no_rv ? 32'h0 : ref_load(f3, addr, rword);

        check("stall_cycles", stalls, exp_stalls);
        check("done_rdata", readdata_m, exp_rd);
        check("done_err", {31'b0, access_err}, {31'b0, no_rv});
        check("done_req", {31'b0, bus_req}, 32'd0);

        // Stray handshake during DONE must be ignored.
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = $urandom;
        @(posedge clk); #1;
        valid_m = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        check("post_rdata", readdata_m, exp_rd);
        check("post_err", {31'b0, access_err}, 32'd0);
        check("post_req", {31'b0, bus_req}, 32'd0);
        check("post_stall", {31'b0, stall_m}, 32'd0);
        n_txn++;
        $display("[TB] txn %0d ld=%0d f3=%0d addr=%h stalls=%0d rdata=%h", n_txn, rd, f3, addr, stalls, readdata_m);
    endtask

    initial begin
        rst = 1'b1;
        valid_m = 1'b1; memread_m = 1'b1; memwrite_m = 1'b0;
        funct3_m = 3'b010; addr_m = 32'h100; wdata_m = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, stall_m}, 32'd0);
        check("rst_req", {31'b0, bus_req}, 32'd0);
        check("rst_we", {31'b0, bus_we}, 32'd0);
        check("rst_wstrb", {28'b0, bus_wstrb}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", readdata_m, 32'd0);
        check("rst_err", {31'b0, access_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; valid_m = 1'b0;

        // LW with grant in the first REQ cycle and data two cycles later
        run_access(1, 1, 0, 3'b010, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF, 0);
        check("lw_value", readdata_m, 32'hDEADBEEF);
        run_access(1, 1, 0, 3'b000, 32'h103, 32'h0, 1, 1, 32'h80FF0000, 0);
        check("lb_value", readdata_m, 32'hFFFFFF80);
        run_access(1, 1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 0);
        check("lbu_value", readdata_m, 32'h00000080);
        run_access(1, 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 32'h0, 0);
        run_access(1, 1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 0);
        run_access(1, 1, 0, 3'b001, 32'h400, 32'h0, 0, 0, 32'h0, 1);
        check("timeout_rdata", readdata_m, 32'h0);

        for (int t = 0; t < 50; t++) begin
            bit          vld, rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            vld = ($urandom_range(0, 9) != 0);
            rd  = $urandom_range(0, 1);
            wr  = rd ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
            f3  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
            a   = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            run_access(vld, rd, wr, f3, a, $urandom, $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom, 0);
        end

        run_access(1, 1, 0, 3'b010, 32'h500, 32'h0, 0, 0, 32'hCAFEF00D, 0);

        // Reset while waiting for read data, then a late rvalid
        @(posedge clk); #1;
        valid_m = 1'b1; memread_m = 1'b1; memwrite_m = 1'b0;
        funct3_m = 3'b010; addr_m = 32'h300;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(negedge clk);
        check("rst_pre_stall", {31'b0, stall_m}, 32'd1);
        @(posedge clk); #1;
        bus_gnt = 1'b0; rst = 1'b1; valid_m = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", {31'b0, stall_m}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'h13572468;
        @(negedge clk);
        check("late_rv_req", {31'b0, bus_req}, 32'd0);
        check("late_rv_stall", {31'b0, stall_m}, 32'd0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("late_rv_rdata", readdata_m, exp_rd);
        check("late_rv_req2", {31'b0, bus_req}, 32'd0);
        check("late_rv_err", {31'b0, access_err}, 32'd0);
        $display("[TB] txn %0d reset mid-load, late rvalid ignored", n_txn + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
